// File: rtl/counter_share_arb.sv
// Round-robin arbiter that lends one up-counter to two requesters, running it
// from 0 to the winner's latched terminal count and pulsing that winner's done.
module counter_share_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic             owner;
  logic             prio;
  logic [WIDTH-1:0] term;
  logic             pick;
  logic             owner_req;

  // prio only matters on a tie; a lone request always wins
  assign pick      = (req0 && req1) ? prio : req1;
  assign owner_req = owner ? req1 : req0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
      term  <= '0;
      q     <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= COUNT;
            owner <= pick;
            gnt0  <= !pick;
            gnt1  <= pick;
            term  <= pick ? len1 : len0;
            q     <= '0;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (!owner_req) begin
            // abort: owner withdrew, hand priority to the other side
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            q     <= '0;
            busy  <= 1'b0;
            prio  <= !owner;
          end else if (q == term) begin
            state <= DONE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= !owner;
            done1 <= owner;
          end else begin
            q <= q + WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
          q     <= '0;
          busy  <= 1'b0;
          prio  <= !owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_share_arb.sv
// Bench for counter_share_arb: directed scenarios plus randomized traffic,
// all outputs compared each cycle against an interval-level reference model.
module tb_counter_share_arb;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] len0 = '0;
  logic [WIDTH-1:0] len1 = '0;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] q;

  int checks = 0;
  int failures = 0;

  counter_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req0(req0), .len0(len0), .req1(req1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  // Reference model: one active interval, k = cycles elapsed since grant.
  // k in 0..term is the counting window, k == term+1 is the done cycle.
  logic m_active = 1'b0;
  logic m_owner  = 1'b0;
  logic m_prio   = 1'b0;
  int   m_term   = 0;
  int   m_k      = 0;
  logic m_win;

  assign m_win = (req0 && req1) ? m_prio : req1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_owner  <= 1'b0;
      m_prio   <= 1'b0;
      m_term   <= 0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_active <= 1'b1;
        m_owner  <= m_win;
        m_term   <= m_win ? int'(len1) : int'(len0);
        m_k      <= 0;
      end
    end else if (m_k <= m_term) begin
      if (!(m_owner ? req1 : req0)) begin
        m_active <= 1'b0;
        m_prio   <= !m_owner;
      end else begin
        m_k <= m_k + 1;
      end
    end else begin
      m_active <= 1'b0;
      m_prio   <= !m_owner;
    end
  end

  logic             e_cnt;
  logic [WIDTH+4:0] exp_vec;
  logic [WIDTH+4:0] obs;
  logic [WIDTH-1:0] e_q;

  always_comb begin
    e_cnt = m_active && (m_k <= m_term);
    e_q   = '0;
    if (m_active) e_q = e_cnt ? WIDTH'(m_k) : WIDTH'(m_term);
    exp_vec = {e_cnt && !m_owner, e_cnt && m_owner,
               m_active && !e_cnt && !m_owner, m_active && !e_cnt && m_owner,
               m_active, e_q};
  end

  assign obs = {gnt0, gnt1, done0, done1, busy, q};

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; len0 = 4'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_hold got=%h exp=0", obs); end
    req0 = 1'b0; rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy cyc=%0d got=%b exp=0", i, busy); end
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL reset_idle_model got=%h exp=%h", obs, exp_vec); end
    end
  endtask

  task automatic test_single();
    int ng0 = 0, nd0 = 0, nb = 0, bad = 0;
    int qs[$];
    len0 = 4'd3; req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL single_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (gnt0) begin ng0++; qs.push_back(int'(q)); end
      if (done0) begin nd0++; req0 = 1'b0; end
      if (busy) nb++;
      if (gnt1 || done1) bad++;
    end
    checks++; if (ng0 != 4) begin failures++; $display("FAIL single_gnt_cycles got=%0d exp=4", ng0); end
    checks++; if (nd0 != 1) begin failures++; $display("FAIL single_done_pulses got=%0d exp=1", nd0); end
    checks++; if (nb != 5) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=5", nb); end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_other_side got=%0d exp=0", bad); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= qs.size() || qs[j] != j) begin
        failures++; $display("FAIL single_q_seq idx=%0d got=%0d exp=%0d", j, (j < qs.size()) ? qs[j] : -1, j);
      end
    end
  endtask

  task automatic test_simultaneous();
    int order[$];
    int nd0 = 0, nd1 = 0, ng0 = 0, ng1 = 0, ovl = 0;
    logic p0, p1;
    rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd1;
    rst = 1'b1;
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL simul_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (gnt0 && !p0) order.push_back(0);
      if (gnt1 && !p1) order.push_back(1);
      p0 = gnt0; p1 = gnt1;
      if (gnt0) ng0++;
      if (gnt1) ng1++;
      if (gnt0 && gnt1) ovl++;
      if (done0) begin nd0++; req0 = 1'b0; end
      if (done1) begin nd1++; req1 = 1'b0; end
    end
    checks++; if (order.size() != 2) begin failures++; $display("FAIL simul_grants got=%0d exp=2", order.size()); end
    checks++; if (order.size() < 1 || order[0] != 0) begin failures++; $display("FAIL simul_first_owner got=%0d exp=0", (order.size() > 0) ? order[0] : -1); end
    checks++; if (order.size() < 2 || order[1] != 1) begin failures++; $display("FAIL simul_second_owner got=%0d exp=1", (order.size() > 1) ? order[1] : -1); end
    checks++; if (ng0 != 3 || ng1 != 2) begin failures++; $display("FAIL simul_gnt_cycles got=%0d/%0d exp=3/2", ng0, ng1); end
    checks++; if (nd0 != 1 || nd1 != 1) begin failures++; $display("FAIL simul_dones got=%0d/%0d exp=1/1", nd0, nd1); end
    checks++; if (ovl != 0) begin failures++; $display("FAIL simul_overlap got=%0d exp=0", ovl); end
    order.delete();
    len0 = 4'd1; len1 = 4'd1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL alt_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (gnt0 && !p0) order.push_back(0);
      if (gnt1 && !p1) order.push_back(1);
      p0 = gnt0; p1 = gnt1;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= order.size() || order[j] != (j % 2)) begin
        failures++; $display("FAIL alt_order idx=%0d got=%0d exp=%0d", j, (j < order.size()) ? order[j] : -1, j % 2);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL alt_drain got=%h exp=%h", obs, exp_vec); end
    end
  endtask

  task automatic test_zero_len();
    int ng1 = 0, nd1 = 0, gi = -10, di = -20;
    int ng0 = 0, nd0 = 0, maxq = 0, prevq = -1, wraps = 0, qdone = -1;
    req1 = 1'b1; len1 = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL zero_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (gnt1) begin
        ng1++; gi = i;
        checks++;
        if (q !== '0) begin failures++; $display("FAIL zero_q got=%0d exp=0", q); end
      end
      if (done1) begin nd1++; di = i; req1 = 1'b0; end
    end
    checks++; if (ng1 != 1) begin failures++; $display("FAIL zero_gnt_cycles got=%0d exp=1", ng1); end
    checks++; if (nd1 != 1 || di != gi + 1) begin failures++; $display("FAIL zero_done got=%0d@%0d exp=1@%0d", nd1, di, gi + 1); end
    req0 = 1'b1; len0 = 4'd15;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL max_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (gnt0) begin
        ng0++;
        if (int'(q) > maxq) maxq = int'(q);
        if (prevq >= 0 && int'(q) != prevq + 1) wraps++;
        prevq = int'(q);
      end
      if (done0) begin nd0++; qdone = int'(q); req0 = 1'b0; end
    end
    checks++; if (ng0 != 16) begin failures++; $display("FAIL max_gnt_cycles got=%0d exp=16", ng0); end
    checks++; if (maxq != 15 || wraps != 0) begin failures++; $display("FAIL max_count got=%0d wraps=%0d exp=15 wraps=0", maxq, wraps); end
    checks++; if (nd0 != 1 || qdone != 15) begin failures++; $display("FAIL max_done got=%0d q=%0d exp=1 q=15", nd0, qdone); end
  endtask

  task automatic test_abort();
    int di = -10, nd0 = 0;
    logic dropped = 1'b0;
    req0 = 1'b1; len0 = 4'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL abort_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (done0) nd0++;
      if (i == di + 1) begin
        checks++;
        if (gnt0 !== 1'b0 || q !== '0) begin failures++; $display("FAIL abort_release got=gnt0:%b q:%0d exp=gnt0:0 q:0", gnt0, q); end
      end
      if (i == di + 2) begin
        checks++;
        if (gnt1 !== 1'b1) begin failures++; $display("FAIL abort_next_grant got=%b exp=1", gnt1); end
      end
      if (gnt0 && !req1 && !dropped) begin req1 = 1'b1; len1 = 4'd2; end
      if (gnt0 && q == 4'd2 && !dropped) begin req0 = 1'b0; dropped = 1'b1; di = i; end
      if (done1) req1 = 1'b0;
    end
    checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL abort_reached_q2 got=%b exp=1", dropped); end
    checks++; if (nd0 != 0) begin failures++; $display("FAIL abort_done0 got=%0d exp=0", nd0); end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    req1 = 1'b1; len1 = 4'd9;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL rmid_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      if (gnt1 && q == 4'd5) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL rmid_reach_q5 got=%b exp=1", found); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL rmid_async_clear got=%h exp=0", obs); end
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL rmid_held got=%h exp=0", obs); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL rmid_first_owner got=%b%b exp=10", gnt0, gnt1); end
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL rmid_model_after got=%h exp=%h", obs, exp_vec); end
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL rmid_drain got=%h exp=%h", obs, exp_vec); end
    end
  endtask

  task automatic test_random();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, obs, exp_vec); end
      checks++;
      if ((gnt0 & gnt1) !== 1'b0 || (done0 & done1) !== 1'b0) begin
        failures++; $display("FAIL rand_exclusive cyc=%0d got=%b%b%b%b exp=no pair", i, gnt0, gnt1, done0, done1);
      end
      if (!req0) req0 = ($urandom_range(0, 2) == 0);
      else if (done0 || $urandom_range(0, 15) == 0) req0 = 1'b0;
      if (!req1) req1 = ($urandom_range(0, 2) == 0);
      else if (done1 || $urandom_range(0, 15) == 0) req1 = 1'b0;
      if ($urandom_range(0, 1) == 0) len0 = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) len1 = WIDTH'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_share_arb.md
Name: counter_share_arb

Overview:
- Shares one 4-bit up-counter between two requesters that each need a timed interval of programmable length.
- Arbitrates between the requesters round-robin and latches the winner's length. It then runs the counter from 0 to that length and returns a one-cycle done pulse to the winner.
- Sits between the requesting control blocks and the counter datapath; it is the sole sequencer of that counter.

Parameters:
- WIDTH, 4, counter and length width; max interval = 2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-low: rst=0 clears all state immediately.
- req0  input  1  requester 0 wants the counter; held high until done0 or abort.
- len0  input  WIDTH  requester 0 terminal count; sampled only at grant.
- req1  input  1  requester 1 request, same rules as req0.
- len1  input  WIDTH  requester 1 terminal count.
- gnt0  output  1  counter owned by requester 0.
- gnt1  output  1  counter owned by requester 1.
- done0  output  1  one-cycle pulse: requester 0 interval complete.
- done1  output  1  one-cycle pulse: requester 1 interval complete.
- busy  output  1  high whenever the state is not IDLE.
- q  output  WIDTH  current counter value.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, q=0, term=0, gnt0/gnt1/done0/done1/busy=0, prio=0 (requester 0 favoured). Outputs go to 0 without waiting for a clock edge.
- All outputs are registered. gnt0 and gnt1 are never high together; done0 and done1 are never high together.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - No request: hold.
  - One request: grant it.
  - Both requests: grant the requester selected by prio.
  - On grant edge: gntX<=1, owner<=X, term<=lenX, q<=0, state<=COUNT.
- COUNT, checked on each edge, in priority order:
  - Owner's req low: abort. state<=IDLE, gnt<=0, q<=0, no done pulse, prio<=other requester.
  - Else if q==term: state<=DONE, gnt<=0, doneX<=1; q holds term.
  - Else: q<=q+1.
- DONE: doneX<=0, q<=0, prio<=other requester, state<=IDLE.
- Timing for len=N, grant at edge E0:
  - gnt high for N+1 cycles; q shows 0..N.
  - done pulse in the cycle after q first equals N.
  - busy high for N+2 cycles.
  - Earliest next grant is at edge E0+N+3.
- Boundary conditions:
  - len=0: gnt high 1 cycle, q=0, done the following cycle.
  - len=2^WIDTH-1: q reaches 15 for WIDTH=4; the counter never wraps because q never exceeds term.
  - lenX changing after grant is ignored; term is latched at grant.
  - The non-owner's req is ignored during COUNT/DONE; it is arbitrated in IDLE with the updated prio.
  - Both requests held continuously: service alternates 0,1,0,1...
  - rst asserted mid-COUNT: immediate reset; no done pulse. After release: IDLE with prio=0.
  - req0 and req1 both rise in the same cycle after reset: requester 0 wins.

Test Plan:
1. Reset. Hold rst=0 with req0=1. Required: all outputs 0. Release rst with no requests: busy stays 0 for 10 cycles.
2. Single request. req0=1, len0=3. Required: gnt0 high 4 cycles with q=0,1,2,3, then done0=1 for exactly one cycle, busy high 5 cycles, gnt1/done1 always 0.
3. Simultaneous requests. req0=req1=1 from reset, len0=2, len1=1, each requester drops req after its done. Required: gnt0 first (q 0..2, done0), then gnt1 (q 0..1, done1), with no gnt overlap. With both reqs held permanently, grant order is 0,1,0,1.
4. Zero length. req1=1, len1=0. Required: gnt1 high 1 cycle with q=0, done1 pulse on the next cycle. Also run len0=15: q counts 0..15 without wrap.
5. Abort. req0=1, len0=7; drop req0 in the cycle q=2. Required: gnt0=0 and q=0 after the next edge, done0 never asserts, and a pending req1 is granted next.
6. Reset mid-operation. Assert rst=0 while q=5 under gnt1. Required: q=0, gnt1=0, busy=0 immediately with no clock edge and no done1. After release with req0=req1=1, requester 0 is granted first.
